imem_arbiter: RTL and testbench

Read arbiter and sequencer for the single-port `InstructionMem` (10-bit word address, 32-bit data, combinational read). It shares that port between the core's instruction-fetch requester and a debug/host read requester. Both requesters use valid/ready request and response channels. Fetch has priority, and a bounded-wait counter guarantees debug progress. The block sits between the fetch stage and `InstructionMem`, and directly drives `io_mem_addr`.

---
 rtl/imem_arbiter_if.sv | 56 +++++
 rtl/imem_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Bundle of the request/response channels and the memory port
//               handled by imem_arbiter.
//               master : requesters + InstructionMem side (environment)
//               slave  : the arbiter itself
//               Signals:
//                 io_fetch_req_*  / io_fetch_resp_*  fetch valid/ready channels
//                 io_dbg_req_*    / io_dbg_resp_*    debug valid/ready channels
//                 io_mem_addr  arbiter -> InstructionMem.io_addr
//                 io_mem_data  InstructionMem.io_data -> arbiter
//                 io_busy      arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              io_fetch_req_valid;
    logic              io_fetch_req_ready;
    logic [ADDR_W-1:0] io_fetch_req_bits_addr;
    logic              io_fetch_resp_valid;
    logic              io_fetch_resp_ready;
    logic [DATA_W-1:0] io_fetch_resp_bits_data;

    logic              io_dbg_req_valid;
    logic              io_dbg_req_ready;
    logic [ADDR_W-1:0] io_dbg_req_bits_addr;
    logic              io_dbg_resp_valid;
    logic              io_dbg_resp_ready;
    logic [DATA_W-1:0] io_dbg_resp_bits_data;

    logic [ADDR_W-1:0] io_mem_addr;
    logic [DATA_W-1:0] io_mem_data;
    logic              io_busy;

    modport master (
        output io_fetch_req_valid, io_fetch_req_bits_addr, io_fetch_resp_ready,
        output io_dbg_req_valid, io_dbg_req_bits_addr, io_dbg_resp_ready,
        output io_mem_data,
        input  io_fetch_req_ready, io_fetch_resp_valid, io_fetch_resp_bits_data,
        input  io_dbg_req_ready, io_dbg_resp_valid, io_dbg_resp_bits_data,
        input  io_mem_addr, io_busy
    );

    modport slave (
        input  io_fetch_req_valid, io_fetch_req_bits_addr, io_fetch_resp_ready,
        input  io_dbg_req_valid, io_dbg_req_bits_addr, io_dbg_resp_ready,
        input  io_mem_data,
        output io_fetch_req_ready, io_fetch_resp_valid, io_fetch_resp_bits_data,
        output io_dbg_req_ready, io_dbg_resp_valid, io_dbg_resp_bits_data,
        output io_mem_addr, io_busy
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Read arbiter/sequencer sharing the single combinational-read
//               InstructionMem port between instruction fetch and a debug
//               requester. One transaction in flight; fetch has priority,
//               a bounded-wait counter lets debug through after MAX_WAIT
//               refused cycles.
//               Ports:
//                 clk   rising-edge clock
//                 reset synchronous, active-high
//                 bus   imem_arbiter_if.slave (request/response channels,
//                       memory address/data, busy flag)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    imem_arbiter_if.slave bus
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_owner;      // 0 = fetch, 1 = debug
    logic [DATA_W-1:0] r_data;
    logic [7:0]        r_wait_cnt;

    logic w_resp_done;
    logic w_grant_ok;
    logic w_dbg_prio;
    logic w_grant_dbg;
    logic w_grant_fetch;
    logic w_handshake;

    // Arbitration. A new request is only taken when the port is free:
    // in IDLE, or in the same cycle the current owner drains its response.
    always_comb begin
        w_resp_done   = 1'b0;
        w_grant_ok    = 1'b0;
        w_dbg_prio    = 1'b0;
        w_grant_dbg   = 1'b0;
        w_grant_fetch = 1'b0;
        w_handshake   = 1'b0;

        w_resp_done   = (r_state == ST_RESP) &&
                        (r_owner ? bus.io_dbg_resp_ready : bus.io_fetch_resp_ready);
        w_grant_ok    = (r_state == ST_IDLE) || w_resp_done;
        w_dbg_prio    = (r_wait_cnt >= c_MAX_WAIT);
        w_grant_dbg   = w_grant_ok && bus.io_dbg_req_valid &&
                        (w_dbg_prio || !bus.io_fetch_req_valid);
        w_grant_fetch = w_grant_ok && bus.io_fetch_req_valid &&
                        !(w_dbg_prio && bus.io_dbg_req_valid);
        w_handshake   = w_grant_dbg || w_grant_fetch;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_handshake) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_resp_done) begin
                    w_state_nxt = w_handshake ? ST_ISSUE : ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_owner    <= 1'b0;
            r_data     <= '0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_handshake) begin
                r_addr  <= w_grant_dbg ? bus.io_dbg_req_bits_addr
                                       : bus.io_fetch_req_bits_addr;
                r_owner <= w_grant_dbg;
            end

            // Memory read is combinational: data is valid while ISSUE
            // presents the address.
            if (r_state == ST_ISSUE) begin
                r_data <= bus.io_mem_data;
            end

            // Counts every refused debug cycle, including while the port is
            // busy or stalled on backpressure; saturates at 255.
            if (w_grant_dbg) begin
                r_wait_cnt <= 8'd0;
            end else if (bus.io_dbg_req_valid && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign bus.io_fetch_req_ready      = w_grant_fetch;
    assign bus.io_dbg_req_ready        = w_grant_dbg;
    assign bus.io_fetch_resp_valid     = (r_state == ST_RESP) && !r_owner;
    assign bus.io_dbg_resp_valid       = (r_state == ST_RESP) &&  r_owner;
    assign bus.io_fetch_resp_bits_data = r_data;
    assign bus.io_dbg_resp_bits_data   = r_data;
    assign bus.io_mem_addr             = r_addr;
    assign bus.io_busy                 = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Self-checking bench for imem_arbiter: directed vector table
//               plus hand-written streaming, starvation, reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    imem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Instruction memory contents: mem[5] = 0x13, elsewhere 0xC0DE0000 | addr
    function automatic logic [31:0] mem_f(input logic [9:0] a);
        return (a == 10'd5) ? 32'h0000_0013 : (32'hC0DE_0000 | {22'd0, a});
    endfunction

    assign bus.io_mem_data = mem_f(bus.io_mem_addr);

    int n_applied = 0;
    int n_miscmp  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [9:0] fa, input logic frr,
                         input logic dv, input logic [9:0] da, input logic drr);
        bus.io_fetch_req_valid     = fv;
        bus.io_fetch_req_bits_addr = fa;
        bus.io_fetch_resp_ready    = frr;
        bus.io_dbg_req_valid       = dv;
        bus.io_dbg_req_bits_addr   = da;
        bus.io_dbg_resp_ready      = drr;
    endtask

    typedef struct {
        logic        fv;  logic [9:0] fa; logic frr;
        logic        dv;  logic [9:0] da; logic drr;
        logic        efr; logic edr; logic efv; logic edv;
        logic [31:0] ed;  logic [9:0] ema; logic eb;
    } vec_t;

    function automatic vec_t mk(
        input logic fv, input logic [9:0] fa, input logic frr,
        input logic dv, input logic [9:0] da, input logic drr,
        input logic efr, input logic edr, input logic efv, input logic edv,
        input logic [31:0] ed, input logic [9:0] ema, input logic eb);
        vec_t v;
        v.fv = fv; v.fa = fa; v.frr = frr; v.dv = dv; v.da = da; v.drr = drr;
        v.efr = efr; v.edr = edr; v.efv = efv; v.edv = edv;
        v.ed = ed; v.ema = ema; v.eb = eb;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        logic [31:0] got_data;
        logic [9:0]  ka;
        int          r;
        bit          busy_ok;

        // fv fa     frr dv da     drr | efr edr efv edv data          maddr  busy
        vecs[0]  = mk(0, 10'd0, 0, 0, 10'd0, 0,  0, 0, 0, 0, 32'h0,        10'd0, 0); // reset state
        vecs[1]  = mk(1, 10'd5, 1, 0, 10'd0, 0,  1, 0, 0, 0, 32'h0,        10'd0, 0); // single fetch
        vecs[2]  = mk(0, 10'd0, 1, 0, 10'd0, 0,  0, 0, 0, 0, 32'h0,        10'd5, 1);
        vecs[3]  = mk(0, 10'd0, 1, 0, 10'd0, 0,  0, 0, 1, 0, 32'h13,       10'd5, 1);
        vecs[4]  = mk(0, 10'd0, 1, 0, 10'd0, 0,  0, 0, 0, 0, 32'h0,        10'd5, 0);
        vecs[5]  = mk(1, 10'd7, 1, 1, 10'd9, 1,  1, 0, 0, 0, 32'h0,        10'd5, 0); // tie: fetch wins
        vecs[6]  = mk(0, 10'd0, 1, 1, 10'd9, 1,  0, 0, 0, 0, 32'h0,        10'd7, 1);
        vecs[7]  = mk(0, 10'd0, 1, 1, 10'd9, 1,  0, 1, 1, 0, 32'hC0DE0007, 10'd7, 1); // dbg in slot
        vecs[8]  = mk(0, 10'd0, 1, 0, 10'd0, 1,  0, 0, 0, 0, 32'h0,        10'd9, 1);
        for (int i = 9; i <= 13; i++)                                               // backpressure
            vecs[i] = mk(1, 10'd3, 1, 0, 10'd0, 0, 0, 0, 0, 1, 32'hC0DE0009, 10'd9, 1);
        vecs[14] = mk(1, 10'd3, 1, 0, 10'd0, 1,  1, 0, 0, 1, 32'hC0DE0009, 10'd9, 1);
        vecs[15] = mk(0, 10'd0, 0, 0, 10'd0, 1,  0, 0, 0, 0, 32'h0,        10'd3, 1);
        vecs[16] = mk(0, 10'd0, 0, 0, 10'd0, 1,  0, 0, 1, 0, 32'hC0DE0003, 10'd3, 1);
        vecs[17] = mk(0, 10'd0, 1, 0, 10'd0, 1,  0, 0, 1, 0, 32'hC0DE0003, 10'd3, 1);
        vecs[18] = mk(0, 10'd0, 1, 0, 10'd0, 1,  0, 0, 0, 0, 32'h0,        10'd3, 0);

        drive(0, 10'd0, 0, 0, 10'd0, 0);
        repeat (2) @(posedge clk);

        // ---------------- vector table ----------------
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(vecs[i].fv, vecs[i].fa, vecs[i].frr, vecs[i].dv, vecs[i].da, vecs[i].drr);
            #1;
            got_data = vecs[i].efv ? bus.io_fetch_resp_bits_data :
                       vecs[i].edv ? bus.io_dbg_resp_bits_data   : 32'h0;
            chk($sformatf("vec%0d", i),
                {17'd0, bus.io_fetch_req_ready, bus.io_dbg_req_ready,
                 bus.io_fetch_resp_valid, bus.io_dbg_resp_valid, bus.io_busy,
                 bus.io_mem_addr, got_data},
                {17'd0, vecs[i].efr, vecs[i].edr, vecs[i].efv, vecs[i].edv, vecs[i].eb,
                 vecs[i].ema, vecs[i].ed});
        end

        // ---------------- streaming 0..7 ----------------
        ka = 10'd0; r = 0; busy_ok = 1'b1;
        for (int cyc = 0; cyc < 40 && r < 8; cyc++) begin
            @(negedge clk);
            drive(ka < 10'd8, ka, 1, 0, 10'd0, 0);
            #1;
            if (cyc >= 1 && !bus.io_busy) busy_ok = 1'b0;
            if (bus.io_fetch_resp_valid) begin
                chk($sformatf("stream_data%0d", r), 64'(bus.io_fetch_resp_bits_data),
                    64'(mem_f(10'(r))));
                chk($sformatf("stream_slot%0d", r), 64'(cyc), 64'(2 + 2 * r));
                r++;
            end
            if (bus.io_fetch_req_ready) ka = ka + 10'd1;
        end
        chk("stream_count", 64'(r), 64'd8);
        chk("stream_busy", 64'(busy_ok), 64'd1);

        // ---------------- starvation bound (MAX_WAIT = 8) ----------------
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            drive(c <= 10, 10'h010, 1, c <= 8, 10'h3FF, 1);
            #1;
            chk($sformatf("starve_fready_c%0d", c), 64'(bus.io_fetch_req_ready),
                64'(c == 0 || c == 2 || c == 4 || c == 6 || c == 10));
            chk($sformatf("starve_dready_c%0d", c), 64'(bus.io_dbg_req_ready), 64'(c == 8));
            chk($sformatf("starve_dvalid_c%0d", c), 64'(bus.io_dbg_resp_valid), 64'(c == 10));
            if (c == 9)  chk("starve_maddr", 64'(bus.io_mem_addr), 64'h3FF);
            if (c == 10) chk("starve_ddata", 64'(bus.io_dbg_resp_bits_data), 64'hC0DE03FF);
        end
        // counter cleared by the debug grant: a fresh tie goes to fetch again
        @(negedge clk);
        drive(1, 10'h010, 1, 1, 10'h3FF, 1);
        #1;
        chk("post_starve_tie", {62'd0, bus.io_fetch_req_ready, bus.io_dbg_req_ready}, 64'b10);

        // ---------------- reset in ISSUE ----------------
        @(negedge clk);
        drive(0, 10'd0, 1, 0, 10'd0, 1);
        reset = 1'b1;
        #1;
        chk("issue_before_reset", {53'd0, bus.io_busy, bus.io_mem_addr}, {53'd1, 10'h010});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_reset",
            {48'd0, bus.io_fetch_req_ready, bus.io_dbg_req_ready, bus.io_fetch_resp_valid,
             bus.io_dbg_resp_valid, bus.io_busy, 1'b0, bus.io_mem_addr}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("no_stale_resp%0d", c),
                {61'd0, bus.io_fetch_resp_valid, bus.io_dbg_resp_valid, bus.io_busy}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
